// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit execute-stage ALU with registered result and condition flag
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       ex_cmd,
    input  logic [1:0]       ALUOp,
    input  logic             branchD,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] result_d;
    logic             flag_d;

    // Shared adders and comparators; both the branch and R/I-type paths reuse them.
    assign sum   = input1 + input2;
    assign diff  = input1 - input2;
    assign shamt = input2[SHW-1:0];
    assign eq    = (input1 == input2);
    assign lt_s  = ($signed(input1) < $signed(input2));
    assign lt_u  = (input1 < input2);

    // Next result and flag from the operation class and command; every code yields a defined value.
    always_comb begin
        result_d = '0;
        flag_d   = 1'b0;
        case (ALUOp)
            2'b00: begin
                result_d = sum;
                flag_d   = 1'b0;
            end
            2'b01: begin
                result_d = diff;
                case (ex_cmd)
                    4'b0001: flag_d = ~eq;
                    4'b0010: flag_d = lt_s;
                    4'b0011: flag_d = ~lt_s;
                    4'b0100: flag_d = lt_u;
                    4'b0101: flag_d = ~lt_u;
                    default: flag_d = eq;
                endcase
                if (branchD) begin
                    flag_d = 1'b0;
                end
            end
            default: begin
                case (ex_cmd)
                    4'b0000: result_d = sum;
                    4'b0001: result_d = diff;
                    4'b0010: result_d = input1 & input2;
                    4'b0011: result_d = input1 | input2;
                    4'b0100: result_d = input1 ^ input2;
                    4'b0101: result_d = ~(input1 | input2);
                    4'b0110: result_d = input1 << shamt;
                    4'b0111: result_d = input1 >> shamt;
                    4'b1000: result_d = $signed(input1) >>> shamt;
                    4'b1001: result_d = {{(WIDTH-1){1'b0}}, lt_s};
                    4'b1010: result_d = {{(WIDTH-1){1'b0}}, lt_u};
                    4'b1011: result_d = input2 << 16;
                    4'b1100: result_d = input1;
                    4'b1101: result_d = input2;
                    4'b1110: result_d = input1 * input2;
                    default: result_d = '0;
                endcase
                flag_d = (result_d == '0) && !branchD;
            end
        endcase
    end

    // Output registers: one-cycle latency, synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out <= '0;
            flag    <= 1'b0;
        end else begin
            alu_out <= result_d;
            flag    <= flag_d;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core against an arithmetic reference model
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [3:0]  ex_cmd;
    logic [1:0]  ALUOp;
    logic        branchD;
    logic [31:0] alu_out;
    logic        flag;

    int n_vec;
    int n_err;

    alu_core #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .input1  (input1),
        .input2  (input2),
        .ex_cmd  (ex_cmd),
        .ALUOp   (ALUOp),
        .branchD (branchD),
        .alu_out (alu_out),
        .flag    (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {flag, result} computed with plain integer arithmetic.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c, input logic [1:0] op,
                                            input logic bd);
        longint unsigned ua, ub, r, p, m;
        longint sa, sb, q;
        int sh;
        logic f;
        m  = 64'd4294967296;
        ua = a;
        ub = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        p  = 64'd1;
        for (int i = 0; i < sh; i++) p = p * 2;
        r = 0;
        f = 1'b0;
        if (op == 2'd0) begin
            r = (ua + ub) % m;
        end else if (op == 2'd1) begin
            r = (ua + m - ub) % m;
            case (c)
                4'd1: f = (ua != ub);
                4'd2: f = (sa < sb);
                4'd3: f = (sa >= sb);
                4'd4: f = (ua < ub);
                4'd5: f = (ua >= ub);
                default: f = (ua == ub);
            endcase
            if (bd) f = 1'b0;
        end else begin
            case (c)
                4'd0:  r = (ua + ub) % m;
                4'd1:  r = (ua + m - ub) % m;
                4'd2:  r = a & b;
                4'd3:  r = a | b;
                4'd4:  r = a ^ b;
                4'd5:  r = (m - 1) - (a | b);
                4'd6:  r = (ua * p) % m;
                4'd7:  r = ua / p;
                4'd8: begin
                    q = sa / longint'(p);
                    if (sa < 0 && (sa % longint'(p)) != 0) q = q - 1;
                    r = longint'(q) + ((q < 0) ? m : 0);
                end
                4'd9:  r = (sa < sb) ? 1 : 0;
                4'd10: r = (ua < ub) ? 1 : 0;
                4'd11: r = (ub * 65536) % m;
                4'd12: r = ua;
                4'd13: r = ub;
                4'd14: r = (ua * ub) % m;
                default: r = 0;
            endcase
            f = (r == 0) && !bd;
        end
        return {f, r[31:0]};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input logic [1:0] op, input logic bd);
        input1  = a;
        input2  = b;
        ex_cmd  = c;
        ALUOp   = op;
        branchD = bd;
    endtask

    // Directed step: expected values written out as constants.
    task automatic step_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic [1:0] op, input logic bd,
                            input logic [31:0] er, input logic ef);
        drive(a, b, c, op, bd);
        @(posedge clk);
        #1;
        check({tag, "_out"}, alu_out, er);
        check({tag, "_flag"}, {31'd0, flag}, {31'd0, ef});
    endtask

    // Model-checked step.
    task automatic step_ref(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, input logic [1:0] op, input logic bd);
        logic [32:0] e;
        e = ref_alu(a, b, c, op, bd);
        drive(a, b, c, op, bd);
        @(posedge clk);
        #1;
        check({tag, "_out"}, alu_out, e[31:0]);
        check({tag, "_flag"}, {31'd0, flag}, {31'd0, e[32]});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(32'd88, 32'd88, 4'b1111, 2'b01, 1'b0);

        // Reset held two edges, then released.
        @(posedge clk); #1;
        check("rst0_out", alu_out, 32'd0);
        check("rst0_flag", {31'd0, flag}, 32'd0);
        @(posedge clk); #1;
        check("rst1_out", alu_out, 32'd0);
        check("rst1_flag", {31'd0, flag}, 32'd0);
        reset = 1'b0;
        step_exp("rel", 32'd88, 32'd88, 4'b1111, 2'b01, 1'b0, 32'd0, 1'b1);

        // Branch compares
        step_exp("beq_ne", 32'd88, 32'd87, 4'b1111, 2'b01, 1'b0, 32'd1, 1'b0);
        step_exp("beq_bd", 32'd88, 32'd88, 4'b0000, 2'b01, 1'b1, 32'd0, 1'b0);
        step_exp("blt_s", 32'hFFFF_FFFF, 32'd1, 4'b0010, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b1);
        step_exp("blt_u", 32'hFFFF_FFFF, 32'd1, 4'b0100, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0);
        step_exp("bge_u", 32'hFFFF_FFFF, 32'd1, 4'b0101, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b1);

        // R-type shifts and subtract
        step_exp("sra", 32'hF000_0000, 32'd4, 4'b1000, 2'b10, 1'b0, 32'hFF00_0000, 1'b0);
        step_exp("srl", 32'hF000_0000, 32'd4, 4'b0111, 2'b10, 1'b0, 32'h0F00_0000, 1'b0);
        step_exp("sll", 32'hF000_0000, 32'd4, 4'b0110, 2'b10, 1'b0, 32'h0000_0000, 1'b1);
        step_exp("sub", 32'hF000_0000, 32'd4, 4'b0001, 2'b10, 1'b0, 32'hEFFF_FFFC, 1'b0);
        step_exp("sh0", 32'h8765_4321, 32'h0000_0020, 4'b1000, 2'b10, 1'b0, 32'h8765_4321, 1'b0);

        // Address add wraps, ex_cmd ignored
        step_exp("addr_a", 32'hFFFF_FFFF, 32'd2, 4'b0000, 2'b00, 1'b0, 32'd1, 1'b0);
        step_exp("addr_b", 32'hFFFF_FFFF, 32'd2, 4'b1110, 2'b00, 1'b0, 32'd1, 1'b0);

        // I-type misc
        step_exp("lui", 32'd0, 32'h0000_1234, 4'b1011, 2'b11, 1'b0, 32'h1234_0000, 1'b0);
        step_exp("mul", 32'd7, 32'd6, 4'b1110, 2'b11, 1'b0, 32'd42, 1'b0);
        step_exp("resv", 32'd7, 32'd6, 4'b1111, 2'b11, 1'b0, 32'd0, 1'b1);
        step_exp("resv_bd", 32'd7, 32'd6, 4'b1111, 2'b11, 1'b1, 32'd0, 1'b0);
        step_exp("slt", 32'hFFFF_FFFF, 32'd1, 4'b1001, 2'b10, 1'b0, 32'd1, 1'b0);
        step_exp("sltu", 32'hFFFF_FFFF, 32'd1, 4'b1010, 2'b10, 1'b0, 32'd0, 1'b1);

        // Randomised back-to-back stream with a mid-stream reset pulse
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b1;
                drive($urandom, $urandom, 4'($urandom), 2'($urandom), 1'b0);
                @(posedge clk); #1;
                check("mid_rst_out", alu_out, 32'd0);
                check("mid_rst_flag", {31'd0, flag}, 32'd0);
                reset = 1'b0;
            end
            step_ref("rnd", rand_operand(), rand_operand(), 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the execute stage of the pipelined processor.
- Operation is selected by a 2-bit class code (ALUOp) from main control and a 4-bit command (ex_cmd) from the ALU-control decode.
- Produces a 32-bit result and a 1-bit branch/condition flag.
- Both outputs are registered and have one-cycle latency.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears output registers.
- input1  input  32  operand A (rs value).
- input2  input  32  operand B (rt value or sign-extended immediate).
- flag  output  1  registered condition flag (branch-taken / compare result).
- ex_cmd  input  4  ALU command / compare-type selector.
- alu_out  output  32  registered ALU result.
- ALUOp  input  2  operation class from main control.
- branchD  input  1  high when the branch was already resolved in decode; suppresses the flag.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: when reset=1 at a rising edge, alu_out<=0 and flag<=0. Reset wins over all other inputs.
- Latency: the combinational result of the inputs sampled at edge N appears on alu_out/flag after edge N. Outputs hold between edges.
- No handshake. A new operation is accepted every cycle.

ALUOp=00 (load/store address):
- alu_out = input1+input2, mod 2^32. ex_cmd is ignored.
- flag = 0.

ALUOp=01 (branch compare):
- alu_out = input1-input2, mod 2^32.
- flag is set by ex_cmd:
  - 0000 EQ
  - 0001 NE
  - 0010 LT signed
  - 0011 GE signed
  - 0100 LTU
  - 0101 GEU
  - all other codes (including 1111) EQ.
- If branchD=1, flag is forced to 0. alu_out is still computed.

ALUOp=10 (R-type) and ALUOp=11 (I-type) share one command table on ex_cmd:
- 0000 ADD
- 0001 SUB
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 NOR
- 0110 SLL: A<<B[4:0]
- 0111 SRL: logical A>>B[4:0]
- 1000 SRA: arithmetic A>>>B[4:0]
- 1001 SLT: signed, result 1/0 zero-extended
- 1010 SLTU: unsigned
- 1011 LUI: B<<16
- 1100 pass A
- 1101 pass B
- 1110 MUL: low 32 bits of A*B
- 1111 reserved: result 0

For ALUOp=10/11:
- flag = (result==0), the zero flag.
- If branchD=1, flag = 0.

Arithmetic rules:
- ADD/SUB wrap silently; no overflow trap.
- Shifts use only bits [4:0] of B. A shift amount of 0 passes A unchanged.
- SRA of a negative value fills with 1s.

Boundary and simultaneous-event rules:
- X-free: every ALUOp/ex_cmd combination yields a defined value.
- A change in ALUOp and ex_cmd in the same cycle is fine: only the values sampled at the edge matter.
- Reset asserted mid-stream clears outputs at that edge. The operation presented in the cycle reset is deasserted is captured at the next edge.

Test Plan:
- Reset: reset=1 for 2 cycles with input1=88, input2=88, ALUOp=01 -> alu_out=0, flag=0. Release reset -> next edge alu_out=0, flag=1.
- Branch compare: input1=88, input2=88, ex_cmd=1111, ALUOp=01, branchD=0 -> alu_out=0, flag=1.
  - input2=87 -> alu_out=1, flag=0.
  - branchD=1 with equal operands -> flag=0.
- Signed vs unsigned compare, ALUOp=01: input1=0xFFFFFFFF, input2=1.
  - ex_cmd=0010 (LT) -> flag=1.
  - ex_cmd=0100 (LTU) -> flag=0.
  - alu_out=0xFFFFFFFE in both cases.
- R-type ops, ALUOp=10, input1=0xF0000000, input2=4:
  - SRA -> 0xFF000000
  - SRL -> 0x0F000000
  - SLL -> 0x00000000, flag=1
  - SUB -> 0xEFFFFFFC
- Address add and wrap, ALUOp=00: input1=0xFFFFFFFF, input2=2 -> alu_out=1, flag=0, independent of ex_cmd.
- Misc, ALUOp=11: LUI with input2=0x1234 -> 0x12340000. MUL 7*6 -> 42. ex_cmd=1111 -> alu_out=0, flag=1.
- Back-to-back: change ops every cycle -> each result appears exactly one edge after its inputs, with no bubbles.
